// File: rtl/rst_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rst_sequencer_pkg
//   Shared definitions for the reset sequencer: state encodings, default
//   parameter values and a helper for sizing the shared delay counter.
// ---------------------------------------------------------------------------
package rst_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_CORE   = 2'd1,
      ST_PERIPH = 2'd2,
      ST_RUN    = 2'd3
   } seq_state_t;

   localparam int LOCK_FILT_DEF = 16;
   localparam int STAGE_DLY_DEF = 8;
   localparam int CNT_W_DEF     = 8;

   // One counter serves both the lock filter and the stage delays, so it is
   // sized for the larger of the two terminal counts (never narrower than 1).
   function automatic int dly_cnt_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// ---------------------------------------------------------------------------
// rst_sequencer_if
//   Lock/reset bundle between the PLL side and the reset sequencer.
//   Signal names are from the sequencer's point of view.
//     i_locked     raw PLL LOCK (asynchronous to the sequencer clock)
//     i_soft_rst   synchronous request to re-run the release sequence
//     o_rst_core   core reset, active-high
//     o_rst_periph peripheral reset, active-high
//     o_ready      all resets released
//     o_loss_cnt   saturating lock-loss event count
//   master: drives lock/soft reset, observes resets (PLL / control side)
//   slave : the sequencer itself
// ---------------------------------------------------------------------------
interface rst_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             i_locked;
   logic             i_soft_rst;
   logic             o_rst_core;
   logic             o_rst_periph;
   logic             o_ready;
   logic [CNT_W-1:0] o_loss_cnt;

   modport master (
      output i_locked,
      output i_soft_rst,
      input  o_rst_core,
      input  o_rst_periph,
      input  o_ready,
      input  o_loss_cnt
   );

   modport slave (
      input  i_locked,
      input  i_soft_rst,
      output o_rst_core,
      output o_rst_periph,
      output o_ready,
      output o_loss_cnt
   );
endinterface

// File: rtl/rst_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level input.
//   Reset forces both flops to 0. Output lags the input by two clocks.
//   Ports: i_clk, i_rst (async, active-high), i_d (async in), o_q (synced).
// ---------------------------------------------------------------------------
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;
endmodule

// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//   Turns raw PLL LOCK into staged resets: core released first, then
//   peripherals, then ready. Lock chatter is filtered; loss of lock re-asserts
//   everything and is counted (saturating) for debug.
//   Ports:
//     i_clk  PLL output clock (only clock of the block)
//     i_rst  asynchronous active-high reset
//     bus    rst_sequencer_if.slave (lock / soft reset in, resets / count out)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   WAIT   | all resets held; counting consecutive synced-lock cycles
//   CORE   | core released, peripherals held; stage delay running
//   PERIPH | core and peripherals released; stage delay running
//   RUN    | everything released, o_ready high
// ---------------------------------------------------------------------------
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int LOCK_FILT = LOCK_FILT_DEF,
   parameter int STAGE_DLY = STAGE_DLY_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   rst_sequencer_if.slave  bus
);

   localparam int               DCW      = dly_cnt_w(LOCK_FILT, STAGE_DLY);
   localparam logic [DCW-1:0]   FILT_TC  = DCW'(LOCK_FILT - 1);
   localparam logic [DCW-1:0]   STAGE_TC = DCW'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] LOSS_MAX = '1;

   logic             w_lock_s;
   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [DCW-1:0]   r_cnt;
   logic [DCW-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0] r_loss_cnt;
   logic [CNT_W-1:0] w_loss_nxt;
   logic             r_rst_core;
   logic             r_rst_periph;
   logic             r_ready;

   sync_2ff u_lock_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (bus.i_locked),
      .o_q   (w_lock_s)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_loss_nxt  = r_loss_cnt;

      if (r_state == ST_WAIT) begin
         // Any low synced-lock cycle (or a soft reset) restarts the filter.
         if (i_soft_rst_w() || !w_lock_s) begin
            w_cnt_nxt = '0;
         end else if (r_cnt == FILT_TC) begin
            w_state_nxt = ST_CORE;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + DCW'(1);
         end
      end else if (!w_lock_s) begin
         // Loss wins over a simultaneous soft reset so the event is counted.
         w_state_nxt = ST_WAIT;
         w_cnt_nxt   = '0;
         if (r_loss_cnt != LOSS_MAX) begin
            w_loss_nxt = r_loss_cnt + CNT_W'(1);
         end
      end else if (i_soft_rst_w()) begin
         w_state_nxt = ST_WAIT;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            ST_CORE: begin
               if (r_cnt == STAGE_TC) begin
                  w_state_nxt = ST_PERIPH;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + DCW'(1);
               end
            end
            ST_PERIPH: begin
               if (r_cnt == STAGE_TC) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + DCW'(1);
               end
            end
            default: begin
               w_cnt_nxt = '0;
            end
         endcase
      end
   end

   function automatic logic i_soft_rst_w();
      return bus.i_soft_rst;
   endfunction

   // Outputs are decoded from the next state so they change on the same
   // edge that enters the state, with no combinational path to the pins.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_WAIT;
         r_cnt        <= '0;
         r_loss_cnt   <= '0;
         r_rst_core   <= 1'b1;
         r_rst_periph <= 1'b1;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_loss_cnt   <= w_loss_nxt;
         r_rst_core   <= (w_state_nxt == ST_WAIT);
         r_rst_periph <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_CORE);
         r_ready      <= (w_state_nxt == ST_RUN);
      end
   end

   assign bus.o_rst_core   = r_rst_core;
   assign bus.o_rst_periph = r_rst_periph;
   assign bus.o_ready      = r_ready;
   assign bus.o_loss_cnt   = r_loss_cnt;

   // Release order: peripherals never out of reset while the core is held,
   // and ready only once both are released.
   a_rst_order : assert property (
      @(posedge i_clk) disable iff (i_rst)
      (!r_rst_periph -> !r_rst_core) && (r_ready -> (!r_rst_core && !r_rst_periph))
   );

endmodule
